mult_arb: RTL and testbench
===========================

MULT_ARB -- requirements
Module: mult_arb

Interface
REQ-001 Parameter MULT_LAT, default 2, SHALL be the fixed cycle count from mult_a/mult_b valid to the matching mult_c; legal range 1..8.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 req0_valid/req1_valid  input  1  SHALL each mean the requester presents an operand pair.
REQ-005 req0_ready/req1_ready  output  1  SHALL each mean the request is accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  32  SHALL be unsigned operands.
REQ-007 rsp0_valid/rsp1_valid  output  1  SHALL each be a one-cycle result strobe.
REQ-008 rsp0_c/rsp1_c  output  64  SHALL carry the product; meaningful only while the matching rsp_valid is high.
REQ-009 mult_a, mult_b  output  32  SHALL drive the shared multiplier operands.
REQ-010 mult_c  input  64  SHALL be the shared multiplier product.
REQ-011 perf_cnt0, perf_cnt1  output  16  SHALL be per-requester accepted-request counters (see Configuration).

Function
REQ-012 A handshake SHALL occur when req_valid and req_ready are both high in the same cycle; at most one handshake per cycle.
REQ-013 req_ready SHALL be combinational from req_valid and arbiter state: only one requester valid -> that requester ready; neither valid -> both ready low.
REQ-014 Both valid -> round-robin: grant the requester not granted at the last handshake; loser's ready low and it must hold valid and operands stable.
REQ-015 Last-grant pointer SHALL update only on a handshake.
REQ-016 Handshake in cycle t -> mult_a/mult_b SHALL hold that pair from cycle t+1; in cycles without a handshake they SHALL hold their previous values.
REQ-017 A tag pipeline of depth 1+MULT_LAT SHALL carry {valid, requester id} per handshake; throughput one request per cycle, back-to-back, no bubbles.
REQ-018 Request accepted in cycle t -> matching rsp_valid high in exactly cycle t+1+MULT_LAT, rsp_c = mult_c combinationally in that cycle.
REQ-019 rsp0_valid and rsp1_valid SHALL never be high in the same cycle; responses are not back-pressurable.
REQ-020 Responses per requester SHALL return in acceptance order; no request SHALL be dropped or duplicated outside reset.
REQ-021 rsp_c of the non-strobed requester SHALL be 0.

Reset
REQ-022 While rst is high: req_ready 0, rsp_valid 0, rsp_c 0, mult_a/mult_b 0, tag pipeline cleared, perf counters 0.
REQ-023 Last-grant pointer SHALL reset to requester 1, so requester 0 wins the first contended cycle.
REQ-024 Reset mid-operation SHALL discard all in-flight tags; no rsp_valid SHALL fire for requests accepted before reset.
REQ-025 First handshake SHALL be possible in the first cycle after rst falls.

Configuration
REQ-026 Macro MULT_ARB_PERF_EN defined -> perf_cnt0/perf_cnt1 SHALL increment on each handshake of their requester, saturating at 0xFFFF.
REQ-027 MULT_ARB_PERF_EN undefined -> perf_cnt0/perf_cnt1 SHALL be tied to 0, counter logic absent; all other behaviour identical.

Verification
REQ-028 Req0 only, 2*2 in cycle t, MULT_LAT=2 -> rsp0_valid in t+3, rsp0_c=4; rsp1_valid stays 0.
REQ-029 Both valid same cycle after reset, req0 8*9, req1 100*100 -> req0 granted first; rsp0_c=72 then rsp1_c=10000 one cycle later.
REQ-030 Both valid for 6 consecutive cycles -> grants alternate 0,1,0,1,0,1; six strobes, each with the correct product.
REQ-031 Req1 0xFFFFFFFF*0xFFFFFFFF -> rsp1_c=0xFFFFFFFE00000001; 0*0xFFFFFFFF -> 0.
REQ-032 Assert rst 1 cycle after 3 back-to-back handshakes -> no rsp_valid fires afterwards; perf counters read 0.
REQ-033 With MULT_ARB_PERF_EN, 70000 req0 handshakes -> perf_cnt0=0xFFFF; without it -> 0.

Source files
------------

// File: rtl/mult_arb.sv
// Two-requester round-robin front end for a shared fixed-latency multiplier.
// Optional feature: define MULT_ARB_PERF_EN for saturating per-requester handshake counters.
module mult_arb #(
   parameter int unsigned MULT_LAT = 2
) (
   input  logic        CLK,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp0_valid,
   output logic [63:0] rsp0_c,
   output logic        rsp1_valid,
   output logic [63:0] rsp1_c,
   output logic [31:0] mult_a,
   output logic [31:0] mult_b,
   input  logic [63:0] mult_c,
   output logic [15:0] perf_cnt0,
   output logic [15:0] perf_cnt1
);

   typedef enum logic {
      GNT0 = 1'b0,
      GNT1 = 1'b1
   } grant_t;

   grant_t            last_grant;
   logic              hs;
   logic              hs_id;
   logic [MULT_LAT:0] tag_v;
   logic [MULT_LAT:0] tag_id;

   // Under contention the requester that did not win the last handshake goes first.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (!rst) begin
         req0_ready = req0_valid & (~req1_valid | (last_grant == GNT1));
         req1_ready = req1_valid & (~req0_valid | (last_grant == GNT0));
      end
   end

   assign hs    = req0_ready | req1_ready;
   assign hs_id = req1_ready;

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         last_grant <= GNT1;
         mult_a     <= '0;
         mult_b     <= '0;
         tag_v      <= '0;
         tag_id     <= '0;
      end else begin
         tag_v  <= {tag_v[MULT_LAT-1:0], hs};
         tag_id <= {tag_id[MULT_LAT-1:0], hs_id};
         if (hs) begin
            last_grant <= hs_id ? GNT1 : GNT0;
            mult_a     <= hs_id ? req1_a : req0_a;
            mult_b     <= hs_id ? req1_b : req0_b;
         end
      end
   end

   // The oldest tag lines up with the product of the pair it was issued with.
   assign rsp0_valid = tag_v[MULT_LAT] & ~tag_id[MULT_LAT];
   assign rsp1_valid = tag_v[MULT_LAT] &  tag_id[MULT_LAT];
   assign rsp0_c     = rsp0_valid ? mult_c : '0;
   assign rsp1_c     = rsp1_valid ? mult_c : '0;

`ifdef MULT_ARB_PERF_EN
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         perf_cnt0 <= '0;
         perf_cnt1 <= '0;
      end else begin
         if (req0_ready && (perf_cnt0 != '1)) perf_cnt0 <= perf_cnt0 + 16'd1;
         if (req1_ready && (perf_cnt1 != '1)) perf_cnt1 <= perf_cnt1 + 16'd1;
      end
   end
`else
   assign perf_cnt0 = '0;
   assign perf_cnt1 = '0;
`endif

endmodule

// File: tb/tb_mult_arb.sv
// Self-checking bench for mult_arb: directed vector table, hand-written corner sequences and
// random traffic checked against a cycle-indexed expected-response scoreboard.
module tb_mult_arb;

   localparam int unsigned L = 2;

   logic        CLK = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp1_valid;
   logic [63:0] rsp0_c, rsp1_c;
   logic [31:0] mult_a, mult_b;
   logic [63:0] mult_c;
   logic [15:0] perf_cnt0, perf_cnt1;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   mult_arb #(.MULT_LAT(L)) dut (
      .CLK(CLK), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_c(rsp0_c), .rsp1_valid(rsp1_valid), .rsp1_c(rsp1_c),
      .mult_a(mult_a), .mult_b(mult_b), .mult_c(mult_c),
      .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1)
   );

   always #5 CLK = ~CLK;

   // Shared multiplier: product appears L cycles after the operands are presented.
   logic [63:0] mpipe [L];
   always @(posedge CLK) begin
      mpipe[0] <= {32'b0, mult_a} * {32'b0, mult_b};
      for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mult_c = mpipe[L-1];

   // Reference model state: expected responses keyed by the cycle they must appear in.
   logic [64:0] exp_q [int];
   logic        m_last = 1'b1;
   logic [31:0] m_ma = '0, m_mb = '0;
   logic [15:0] m_cnt0 = '0, m_cnt1 = '0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic mon_cycle();
      logic        e0, e1, has, id;
      logic [64:0] e;
      logic [31:0] a, b;
      if (rst) begin
         exp_q.delete();
         m_last = 1'b1; m_ma = '0; m_mb = '0; m_cnt0 = '0; m_cnt1 = '0;
      end
      e0 = !rst && req0_valid && (!req1_valid || m_last);
      e1 = !rst && req1_valid && (!req0_valid || !m_last);
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("mult_a", mult_a, m_ma);
      chk("mult_b", mult_b, m_mb);
      has = exp_q.exists(cyc);
      e = has ? exp_q[cyc] : '0;
      if (has) exp_q.delete(cyc);
      chk("rsp0_valid", rsp0_valid, has && !e[64]);
      chk("rsp1_valid", rsp1_valid, has && e[64]);
      chk("rsp0_c", rsp0_c, (has && !e[64]) ? e[63:0] : 64'd0);
      chk("rsp1_c", rsp1_c, (has && e[64]) ? e[63:0] : 64'd0);
`ifdef MULT_ARB_PERF_EN
      chk("perf_cnt0", perf_cnt0, m_cnt0);
      chk("perf_cnt1", perf_cnt1, m_cnt1);
`else
      chk("perf_cnt0", perf_cnt0, 64'd0);
      chk("perf_cnt1", perf_cnt1, 64'd0);
`endif
      if (e0 || e1) begin
         id = e1;
         a  = e1 ? req1_a : req0_a;
         b  = e1 ? req1_b : req0_b;
         exp_q[cyc + 1 + L] = {id, {32'b0, a} * {32'b0, b}};
         m_last = id; m_ma = a; m_mb = b;
         if (e0 && m_cnt0 != 16'hFFFF) m_cnt0++;
         if (e1 && m_cnt1 != 16'hFFFF) m_cnt1++;
      end
      cyc++;
   endtask

   task automatic to_neg();
      @(negedge CLK);
      mon_cycle();
   endtask

   task automatic to_next();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin to_neg(); to_next(); end
   endtask

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   task automatic drain();
      logic acc0, acc1;
      for (int i = 0; i < 8; i++) begin
         if (!req0_valid && !req1_valid) break;
         to_neg();
         acc0 = req0_valid && req0_ready;
         acc1 = req1_valid && req1_ready;
         to_next();
         if (acc0) req0_valid = 1'b0;
         if (acc1) req1_valid = 1'b0;
      end
      chk("drain_done", {req0_valid, req1_valid}, 64'd0);
      idle(L + 2);
   endtask

   task automatic run_random(input int n);
      logic acc0, acc1;
      for (int i = 0; i < n; i++) begin
         to_neg();
         acc0 = req0_valid && req0_ready;
         acc1 = req1_valid && req1_ready;
         to_next();
         if (!req0_valid || acc0) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req0_a = rand_op(); req0_b = rand_op();
         end
         if (!req1_valid || acc1) begin
            req1_valid = ($urandom_range(0, 3) != 0);
            req1_a = rand_op(); req1_b = rand_op();
         end
      end
   endtask

   typedef struct {
      logic        v0;
      logic [31:0] a0, b0;
      logic        v1;
      logic [31:0] a1, b1;
      logic        r0, r1;
   } vec_t;

   vec_t vecs [12];

   initial begin
      vecs[0]  = '{1'b1, 32'd8, 32'd9, 1'b1, 32'd100, 32'd100, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 32'd3, 32'd5, 1'b1, 32'd100, 32'd100, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 32'd3, 32'd5, 1'b1, 32'd7, 32'd11, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 32'd0, 32'hFFFFFFFF, 1'b1, 32'd7, 32'd11, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, 32'd0, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 32'd6, 32'd6, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1};
      vecs[6]  = '{1'b1, 32'd6, 32'd6, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 32'd0, 32'd0, 1'b1, 32'd2, 32'd3, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 32'd0, 32'd0, 1'b1, 32'd4, 32'd4, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 32'd5, 32'd5, 1'b1, 32'd9, 32'd9, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 32'd0, 32'd0, 1'b1, 32'd9, 32'd9, 1'b0, 1'b1};

      rst = 1'b0;
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1;
      req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1;
      #1 rst = 1'b1;
      idle(3);

      // Table starts in the first cycle after reset falls.
      rst = 1'b0;
      foreach (vecs[i]) begin
         req0_valid = vecs[i].v0; req0_a = vecs[i].a0; req0_b = vecs[i].b0;
         req1_valid = vecs[i].v1; req1_a = vecs[i].a1; req1_b = vecs[i].b1;
         to_neg();
         chk($sformatf("vec%0d_r0", i), req0_ready, vecs[i].r0);
         chk($sformatf("vec%0d_r1", i), req1_ready, vecs[i].r1);
         to_next();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      idle(L + 3);

      // Single request latency.
      req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd2;
      to_neg(); chk("lat_ready", req0_ready, 1'b1); to_next();
      req0_valid = 1'b0;
      idle(L);
      to_neg();
      chk("lat_rsp0_valid", rsp0_valid, 1'b1);
      chk("lat_rsp0_c", rsp0_c, 64'd4);
      chk("lat_rsp1_valid", rsp1_valid, 1'b0);
      to_next();
      idle(2);

      // Operand extremes on requester 1, back to back.
      req1_valid = 1'b1; req1_a = 32'hFFFFFFFF; req1_b = 32'hFFFFFFFF;
      to_neg(); to_next();
      req1_a = 32'h0;
      to_neg(); to_next();
      req1_valid = 1'b0;
      idle(L - 1);
      to_neg();
      chk("max_rsp1_valid", rsp1_valid, 1'b1);
      chk("max_rsp1_c", rsp1_c, 64'hFFFFFFFE00000001);
      to_next();
      to_neg();
      chk("zero_rsp1_valid", rsp1_valid, 1'b1);
      chk("zero_rsp1_c", rsp1_c, 64'd0);
      to_next();
      idle(2);

      // Reset with three requests in flight.
      req0_valid = 1'b1;
      for (int i = 3; i < 6; i++) begin
         req0_a = i; req0_b = i;
         to_neg(); to_next();
      end
      req0_valid = 1'b0; rst = 1'b1;
      to_neg(); to_next();
      rst = 1'b0;
      for (int i = 0; i < L + 3; i++) begin
         to_neg();
         chk("rst_rsp0_valid", rsp0_valid, 1'b0);
         chk("rst_rsp1_valid", rsp1_valid, 1'b0);
         to_next();
      end
      chk("rst_perf0", perf_cnt0, 64'd0);
      chk("rst_perf1", perf_cnt1, 64'd0);

      run_random(400);
      drain();

`ifdef MULT_ARB_PERF_EN
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1;
      idle(70000);
      req0_valid = 1'b0;
      to_neg(); chk("perf_sat", perf_cnt0, 64'hFFFF); to_next();
`else
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1;
      idle(40);
      req0_valid = 1'b0;
      to_neg(); chk("perf_off", perf_cnt0, 64'd0); to_next();
`endif
      idle(L + 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
